fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end. It holds the PC register, issues one
// instruction-memory request per cycle, and keeps a two-entry
// {pc, instr} queue that feeds decode. A redirect from the PC-select
// stage reloads the PC, flushes the queue and drops any response that
// is still in flight.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   redirect_valid    taken branch/jump this cycle
//   redirect_pc       redirect target; the low two bits are ignored
//   fetch_pc          current PC register value
//   imem_req          instruction memory request
//   imem_addr         request address
//   imem_ready        memory accepts the request this cycle
//   imem_rdata        instruction word, one cycle after an accepted request
//   id_valid          instruction presented to decode
//   id_ready          decode takes the presented instruction
//   id_pc, id_instr   PC and word of the presented instruction

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0] pc_q;
    entry_t      fifo_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic        busy_q;
    logic        kill_q;
    logic [31:0] inflight_pc_q;

    logic        pop;
    logic        push;
    logic        accept;
    logic [2:0]  occupancy;
    entry_t      head;

    assign fetch_pc  = pc_q;
    assign imem_addr = pc_q;
    assign head      = fifo_q[rd_ptr_q];

    // Requests are throttled so that queued entries plus the one in-flight
    // response never exceed the two queue slots, counting the slot freed by
    // a pop this cycle. Redirect and reset suppress both requests and pops.
    always_comb begin
        id_valid  = (count_q != 2'd0) && !redirect_valid && !rst;
        pop       = id_valid && id_ready;
        occupancy = {1'b0, count_q} + {2'b00, busy_q} - {2'b00, pop};
        imem_req  = !rst && !redirect_valid && (occupancy < 3'd2);
        accept    = imem_req && imem_ready;
        push      = busy_q && !kill_q && !redirect_valid;
        if (count_q == 2'd0) begin
            id_pc    = 32'h0;
            id_instr = NOP;
        end else begin
            id_pc    = head.pc;
            id_instr = head.instr;
        end
    end

    // PC register: a redirect wins over an accepted request; the +4
    // wraps naturally at the top of the address space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // In-flight tracker. The response arrives exactly one cycle after
    // acceptance, so busy only ever lasts a single cycle. kill marks a
    // response whose redirect has already flushed the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= 1'b0;
            kill_q        <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else if (accept) begin
            busy_q        <= 1'b1;
            kill_q        <= 1'b0;
            inflight_pc_q <= pc_q;
        end else begin
            busy_q <= 1'b0;
            if (redirect_valid && busy_q) begin
                kill_q <= 1'b1;
            end
        end
    end

    // Two-entry queue with read/write pointers. A simultaneous push and
    // pop leaves the count alone; a redirect empties it outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (redirect_valid) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: imem_rdata};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The request throttle guarantees a response never lands on a full queue.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. A memory model answers every
// accepted request one cycle later with a word derived from its address.
// A scoreboard queue receives {pc, instr, cycle when decode may see it}
// for each accepted request and is popped whenever decode takes an
// instruction; every cycle the DUT outputs are compared on the falling edge.

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          readyCycle;
    } expEntry_t;

    logic        clk;
    logic        rst;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic [31:0] fetchPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic        idValid;
    logic        idReady;
    logic [31:0] idPc;
    logic [31:0] idInstr;

    int          compareCount  = 0;
    int          mismatchCount = 0;
    int          cycle         = 0;
    expEntry_t   expQ[$];
    logic [31:0] modelPc       = RESET_PC;
    logic        expValid;
    logic        expPop;
    logic        expReq;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .fetch_pc       (fetchPc),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_ready     (imemReady),
        .imem_rdata     (imemRdata),
        .id_valid       (idValid),
        .id_ready       (idReady),
        .id_pc          (idPc),
        .id_instr       (idInstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word stored at an address; differs from the address so a pc/instr
    // swap cannot go unnoticed.
    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return addr ^ 32'h1357_0000;
    endfunction

    // Memory answers one cycle after acceptance; otherwise it returns junk
    // that must never appear at decode.
    always @(posedge clk) begin
        if (imemReq && imemReady) imemRdata <= instrOf(imemAddr);
        else                      imemRdata <= 32'hBAD0_BAD0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
                     tag, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles, input logic redir,
                                 input logic [31:0] rpc, input logic memRdy,
                                 input logic decRdy);
        redirectValid = redir;
        redirectPc    = rpc;
        imemReady     = memRdy;
        idReady       = decRdy;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input int cycles);
        rst = 1'b1;
        applyStimulus(cycles, 1'b0, 32'h0, 1'b1, 1'b1);
        rst = 1'b0;
    endtask

    // Scoreboard: decide what the DUT must show this cycle, compare it,
    // then advance the expectation to what the next rising edge does.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            checkOutput("rstReq",   {31'b0, imemReq}, 32'h0);
            checkOutput("rstValid", {31'b0, idValid}, 32'h0);
            checkOutput("rstIdPc",  idPc,    32'h0);
            checkOutput("rstInstr", idInstr, NOP);
            checkOutput("rstPc",    fetchPc, RESET_PC);
            expQ.delete();
            modelPc = RESET_PC;
        end else begin
            expValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cycle) &&
                       !redirectValid;
            expPop   = expValid && idReady;
            expReq   = !redirectValid &&
                       ((expQ.size() - (expPop ? 1 : 0)) < 2);

            checkOutput("fetchPc", fetchPc, modelPc);
            checkOutput("imemReq", {31'b0, imemReq}, {31'b0, expReq});
            checkOutput("idValid", {31'b0, idValid}, {31'b0, expValid});
            if (expReq) checkOutput("imemAddr", imemAddr, modelPc);
            if (expValid) begin
                checkOutput("idPc",    idPc,    expQ[0].pc);
                checkOutput("idInstr", idInstr, expQ[0].instr);
            end else if (expQ.size() == 0 || expQ[0].readyCycle > cycle) begin
                checkOutput("emptyPc",    idPc,    32'h0);
                checkOutput("emptyInstr", idInstr, NOP);
            end

            if (redirectValid) begin
                expQ.delete();
                modelPc = {redirectPc[31:2], 2'b00};
            end else begin
                if (expPop) void'(expQ.pop_front());
                if (expReq && imemReady) begin
                    expQ.push_back('{pc: modelPc, instr: instrOf(modelPc),
                                     readyCycle: cycle + 2});
                    modelPc = modelPc + 32'd4;
                end
            end
        end
    end

    initial begin
        logic        redir;
        logic [31:0] target;

        rst           = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        imemReady     = 1'b0;
        idReady       = 1'b0;

        // Streaming at full rate straight out of reset.
        resetDut(3);
        applyStimulus(10, 1'b0, 32'h0, 1'b1, 1'b1);

        // Decode stalled from the start: two entries buffered, PC parked at 8.
        resetDut(2);
        applyStimulus(6, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("fullHoldPc", fetchPc, 32'h8);
        checkOutput("fullNoReq",  {31'b0, imemReq}, 32'h0);
        applyStimulus(8, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect while a response is in flight and the queue is occupied.
        resetDut(2);
        applyStimulus(4, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        checkOutput("redirAddr", imemAddr, 32'h0000_0100);
        applyStimulus(8, 1'b0, 32'h0, 1'b1, 1'b1);

        // Unaligned redirect target is truncated to a word boundary.
        applyStimulus(1, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
        checkOutput("redirAlign", fetchPc, 32'h0000_0200);
        applyStimulus(4, 1'b0, 32'h0, 1'b1, 1'b1);

        // Memory stalls for three cycles mid-stream.
        applyStimulus(3, 1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(6, 1'b0, 32'h0, 1'b1, 1'b1);

        // PC wraps past the top of the address space.
        applyStimulus(1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        applyStimulus(2, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrapPc", fetchPc, 32'h0000_0000);
        applyStimulus(6, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset asserted mid-stream with work queued and in flight.
        applyStimulus(3, 1'b0, 32'h0, 1'b1, 1'b0);
        resetDut(1);
        applyStimulus(6, 1'b0, 32'h0, 1'b1, 1'b1);

        // Random handshakes with occasional redirects, some near the wrap.
        for (int i = 0; i < 400; i++) begin
            redir  = ($urandom_range(0, 12) == 0);
            target = $urandom;
            if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 | (target & 32'hF);
            applyStimulus(1, redir, target, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(6, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule
